// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file write-back control slice.
package regfile_ctrl_pkg;

  localparam int unsigned DEF_IS_DEPTH   = 5;
  localparam int unsigned DEF_REGF_DEPTH = 32;
  localparam int unsigned DEF_REGF_WIDTH = 32;
  localparam int unsigned DEF_MAX_WAIT   = 4;

  typedef enum logic {
    PRIO_A,
    PRIO_B
  } arb_state_t;

  typedef logic [DEF_IS_DEPTH-1:0] reg_addr_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: tracks outstanding
// registers, answers decode-stage hazard queries and flags unexpected B writes.
module wb_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned IS_DEPTH   = DEF_IS_DEPTH,
  parameter int unsigned REGF_DEPTH = DEF_REGF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_long,
  input  logic [IS_DEPTH-1:0] iss_rd,
  input  logic                b_grant,
  input  logic [IS_DEPTH-1:0] b_rd,
  input  logic [IS_DEPTH-1:0] q_rs1,
  input  logic [IS_DEPTH-1:0] q_rs2,
  input  logic [IS_DEPTH-1:0] q_rd,
  output logic                hazard,
  output logic                sb_err
);

  logic [REGF_DEPTH-1:0] pending;
  logic [REGF_DEPTH-1:0] pending_nxt;
  logic [REGF_DEPTH-1:0] set_vec;
  logic [REGF_DEPTH-1:0] clr_vec;
  logic                  err_hit;

  // Next pending vector: clear first, then set, so a same-cycle re-issue stays outstanding.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_long && (iss_rd != '0)) set_vec[iss_rd] = 1'b1;
    if (b_grant) clr_vec[b_rd] = 1'b1;
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
    err_hit        = b_grant && (b_rd != '0) && !pending[b_rd];
  end

  // Hazard lookup reads registered state only.
  always_comb begin
    hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd];
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (err_hit) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline write-back (A) and a
// multi-cycle unit (B), with starvation protection for B and a pending scoreboard.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned IS_DEPTH   = DEF_IS_DEPTH,
  parameter int unsigned REGF_DEPTH = DEF_REGF_DEPTH,
  parameter int unsigned REGF_WIDTH = DEF_REGF_WIDTH,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [IS_DEPTH-1:0]   a_rd,
  input  logic [REGF_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [IS_DEPTH-1:0]   b_rd,
  input  logic [REGF_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  iss_long,
  input  logic [IS_DEPTH-1:0]   iss_rd,
  input  logic [IS_DEPTH-1:0]   q_rs1,
  input  logic [IS_DEPTH-1:0]   q_rs2,
  input  logic [IS_DEPTH-1:0]   q_rd,
  output logic                  hazard,
  output logic                  rf_we,
  output logic [IS_DEPTH-1:0]   rf_rd,
  output logic [REGF_WIDTH-1:0] rf_wdata,
  output logic                  sb_err
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  arb_state_t     state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           grant_a, grant_b;

  // Grant, write-port mux, wait counter and priority next-state.
  // Grants are gated by reset so they drop the moment reset asserts.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wdata  = '0;
    wait_nxt  = wait_cnt;
    state_nxt = state;

    if (rst) begin
      if (state == PRIO_A) begin
        if (a_valid)      grant_a = 1'b1;
        else if (b_valid) grant_b = 1'b1;
      end else begin
        if (b_valid)      grant_b = 1'b1;
        else if (a_valid) grant_a = 1'b1;
      end
    end

    if (grant_a) begin
      rf_rd    = a_rd;
      rf_wdata = a_data;
      rf_we    = (a_rd != '0);
    end else if (grant_b) begin
      rf_rd    = b_rd;
      rf_wdata = b_data;
      rf_we    = (b_rd != '0);
    end

    if (!b_valid || grant_b)   wait_nxt = '0;
    else if (wait_cnt < WAIT_MAX) wait_nxt = wait_cnt + 1'b1;

    case (state)
      PRIO_A:  if (b_valid && !grant_b && (wait_nxt == WAIT_MAX)) state_nxt = PRIO_B;
      PRIO_B:  if (grant_b) state_nxt = PRIO_A;
      default: state_nxt = PRIO_A;
    endcase
  end

  always_comb begin
    a_ready = grant_a;
    b_ready = grant_b;
  end

  // Arbiter state and B wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PRIO_A;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  wb_scoreboard #(
    .IS_DEPTH   (IS_DEPTH),
    .REGF_DEPTH (REGF_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_long (iss_long),
    .iss_rd   (iss_rd),
    .b_grant  (grant_b),
    .b_rd     (b_rd),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_rd     (q_rd),
    .hazard   (hazard),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a negedge-capturing register file model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  regfile_wb_arbiter #(
    .IS_DEPTH   (5),
    .REGF_DEPTH (32),
    .REGF_WIDTH (32),
    .MAX_WAIT   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .iss_long (iss_long),
    .iss_rd   (iss_rd),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_rd     (q_rd),
    .hazard   (hazard),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .sb_err   (sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: captures on the negedge following a granted write.
  always @(negedge clk) begin
    if (rf_we) regs[rf_rd] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h2222_2222;
    iss_long = 1'b0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;

    // Reset with both requesters active: nothing granted.
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_sb_err", sb_err, 0);
    tick();
    tick();

    // Release: PRIO_A, A wins first.
    rst = 1'b1;
    #1;
    chk("rel_a_ready", a_ready, 1);
    chk("rel_b_ready", b_ready, 0);
    chk("rel_rf_rd", rf_rd, 3);
    b_valid = 1'b0;
    tick();

    // A only write to x5.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    chk("a_only_ready", a_ready, 1);
    chk("a_only_we", rf_we, 1);
    chk("a_only_rd", rf_rd, 5);
    chk("a_only_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    a_valid = 1'b0;
    #1;
    chk("x5_readback", regs[5], 32'hDEAD_BEEF);
    chk("idle_we", rf_we, 0);
    chk("idle_rd", rf_rd, 0);
    chk("idle_wdata", rf_wdata, 0);

    // Issue long ops to x7 and x8.
    iss_long = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7;
    #1;
    chk("hz_same_cycle", hazard, 0);
    tick();
    iss_rd = 5'd8;
    #1;
    chk("hz_x7_pending", hazard, 1);
    tick();
    iss_long = 1'b0; q_rs1 = '0; q_rd = 5'd8;
    #1;
    chk("hz_x8_qrd", hazard, 1);

    // Starvation: A gets 4 grants, B the 5th, then A again.
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hAAAA_0001;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'hBBBB_0008;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_a_ready", a_ready, 1);
      chk("starve_b_ready", b_ready, 0);
      tick();
    end
    #1;
    chk("starve5_b_ready", b_ready, 1);
    chk("starve5_a_ready", a_ready, 0);
    chk("starve5_rf_rd", rf_rd, 8);
    chk("starve5_rf_wdata", rf_wdata, 32'hBBBB_0008);
    chk("starve5_hz_held", hazard, 1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("after_b_a_ready", a_ready, 1);
    chk("x8_cleared", hazard, 0);
    chk("x8_readback", regs[8], 32'hBBBB_0008);
    chk("no_err_x8", sb_err, 0);
    tick();

    // B completes x7: hazard drops the next cycle.
    a_valid = 1'b0; q_rd = '0; q_rs2 = 5'd7;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777_7777;
    #1;
    chk("b7_ready", b_ready, 1);
    chk("b7_hz_still", hazard, 1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("b7_hz_clear", hazard, 0);

    // Same-cycle set and clear of x7: stays pending.
    iss_long = 1'b1; iss_rd = 5'd7;
    tick();
    b_valid = 1'b1; b_rd = 5'd7;
    tick();
    iss_long = 1'b0; b_valid = 1'b0;
    #1;
    chk("setclr_pending", hazard, 1);
    chk("setclr_no_err", sb_err, 0);
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    #1;
    chk("setclr_drained", hazard, 0);

    // x0 write completes handshake but is suppressed.
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_a_ready", a_ready, 1);
    chk("x0_rf_we", rf_we, 0);
    tick();
    a_valid = 1'b0;

    // B write to x9 that was never issued: sticky error.
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999_9999;
    #1;
    chk("b9_ready", b_ready, 1);
    chk("b9_err_not_yet", sb_err, 0);
    tick();
    b_valid = 1'b0;
    #1;
    chk("b9_err_set", sb_err, 1);
    tick();
    tick();
    chk("b9_err_sticky", sb_err, 1);

    // Reset mid-handshake with a pending register.
    iss_long = 1'b1; iss_rd = 5'd12; q_rs1 = 5'd12;
    tick();
    iss_long = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst2_a_ready", a_ready, 0);
    chk("rst2_b_ready", b_ready, 0);
    chk("rst2_rf_we", rf_we, 0);
    chk("rst2_sb_err", sb_err, 0);
    chk("rst2_hazard", hazard, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
